// File: rtl/matriz_carga_det_pkg.sv
// matriz_carga_det_pkg: shared widths, FSM states and element offset for the matrix loaders
package matriz_carga_det_pkg;
  localparam int ELEM_W = 8;
  localparam int DIM = 5;
  localparam int MAT_W = DIM * DIM * ELEM_W;
  localparam int TIMEOUT = 32;
  localparam int IDX_W = $clog2(DIM) + 1;
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;
  function automatic int elem_off(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
    return (int'(r) * DIM + int'(c)) * ELEM_W;
  endfunction
endpackage

// File: rtl/matriz_carga_det_if.sv
// matriz_carga_det_if: command, element stream, determinant-unit and result signals of the loader
interface matriz_carga_det_if;
  import matriz_carga_det_pkg::*;
  logic op_begin;
  logic [2:0] size;
  logic in_valid;
  logic in_ready;
  logic [ELEM_W-1:0] in_data;
  logic [MAT_W-1:0] matriz_A;
  logic start;
  logic done_in;
  logic [ELEM_W-1:0] det_in;
  logic [ELEM_W-1:0] result;
  logic result_valid;
  logic busy;
  logic error;
  modport master (
    output op_begin, size, in_valid, in_data, done_in, det_in,
    input in_ready, matriz_A, start, result, result_valid, busy, error
  );
  modport slave (
    input op_begin, size, in_valid, in_data, done_in, det_in,
    output in_ready, matriz_A, start, result, result_valid, busy, error
  );
endinterface

// File: rtl/matriz_carga_det_idx_cnt.sv
// matriz_idx_cnt: row-major row/col counter wrapping at N with clear, advance and last-element flag
module matriz_idx_cnt
  import matriz_carga_det_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [2:0]       n,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d, nm1;
  logic wrap;
  // col wraps to 0 at N-1 and carries into row; clear wins over advance
  always_comb begin
    nm1 = IDX_W'(n) - IDX_W'(1);
    wrap = col_q == nm1;
    row_d = clr ? '0 : (adv && wrap) ? row_q + IDX_W'(1) : row_q;
    col_d = clr ? '0 : adv ? (wrap ? '0 : col_q + IDX_W'(1)) : col_q;
  end
  // index registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  assign row = row_q;
  assign col = col_q;
  assign last = wrap && row_q == nm1;
endmodule

// File: rtl/matriz_carga_det.sv
// matriz_carga_det: loads an NxN matrix element stream, runs the determinant unit and returns det
module matriz_carga_det
  import matriz_carga_det_pkg::*;
(
  input logic clk,
  input logic rst,
  matriz_carga_det_if.slave bus
);
  state_t state_q, state_d;
  logic [2:0] n_q, n_d;
  logic [MAT_W-1:0] mat_q, mat_d;
  logic [ELEM_W-1:0] result_q, result_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic start_q, start_d, in_ready_q, in_ready_d, rv_q, rv_d, busy_q, busy_d, error_q, error_d;
  logic clr, adv, last;
  logic [IDX_W-1:0] row, col;

  matriz_idx_cnt u_idx (.clk, .rst, .clr, .adv, .n(n_q), .row, .col, .last);

  // sequencing, packing, timeout and capture; outputs come from the next state so they are registered
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    mat_d = mat_q;
    result_d = result_q;
    tmo_d = '0;
    error_d = 1'b0;
    clr = 1'b0;
    adv = 1'b0;
    case (state_q)
      ST_IDLE:
        if (bus.op_begin) begin
          if (bus.size >= 3'd2 && bus.size <= 3'd5) begin
            n_d = bus.size;
            mat_d = '0;
            clr = 1'b1;
            state_d = ST_LOAD;
          end else error_d = 1'b1;
        end
      ST_LOAD:
        if (bus.in_valid && in_ready_q) begin
          mat_d[elem_off(row, col) +: ELEM_W] = bus.in_data;
          adv = 1'b1;
          state_d = last ? ST_RUN : ST_LOAD;
        end
      ST_RUN: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (bus.done_in && start_q) begin
          result_d = bus.det_in;
          state_d = ST_DONE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          result_d = '0;
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    start_d = state_d == ST_RUN;
    in_ready_d = state_d == ST_LOAD;
    rv_d = state_d == ST_DONE;
    busy_d = state_d != ST_IDLE;
  end

  // state and registered outputs; reset aborts any operation at once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      n_q <= '0;
      mat_q <= '0;
      result_q <= '0;
      tmo_q <= '0;
      start_q <= 1'b0;
      in_ready_q <= 1'b0;
      rv_q <= 1'b0;
      busy_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      mat_q <= mat_d;
      result_q <= result_d;
      tmo_q <= tmo_d;
      start_q <= start_d;
      in_ready_q <= in_ready_d;
      rv_q <= rv_d;
      busy_q <= busy_d;
      error_q <= error_d;
    end

  assign bus.in_ready = in_ready_q;
  assign bus.matriz_A = mat_q;
  assign bus.start = start_q;
  assign bus.result = result_q;
  assign bus.result_valid = rv_q;
  assign bus.busy = busy_q;
  assign bus.error = error_q;
endmodule

// File: tb/tb_matriz_carga_det.sv
// tb_matriz_carga_det: randomized self-checking bench with a behavioural determinant unit
module tb_matriz_carga_det;
  import matriz_carga_det_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  matriz_carga_det_if bus ();
  matriz_carga_det dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, dcnt = 0, det_dly = 6, cur_n = 2, dn_cyc = 0;
  bit det_never = 1'b0;
  int el[25];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint det_f(input logic [MAT_W-1:0] mv, input int n);
    longint m[5][5];
    longint prev, t;
    int sgn, p;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) m[i][j] = longint'(mv[(i * DIM + j) * ELEM_W +: ELEM_W]);
    sgn = 1;
    prev = 1;
    for (int k = 0; k < n - 1; k++) begin
      if (m[k][k] == 0) begin
        p = -1;
        for (int i = k + 1; i < n; i++) if (m[i][k] != 0 && p < 0) p = i;
        if (p < 0) return 0;
        for (int j = 0; j < 5; j++) begin
          t = m[k][j];
          m[k][j] = m[p][j];
          m[p][j] = t;
        end
        sgn = -sgn;
      end
      for (int i = k + 1; i < n; i++)
        for (int j = k + 1; j < n; j++) m[i][j] = (m[i][j] * m[k][k] - m[i][k] * m[k][j]) / prev;
      prev = m[k][k];
    end
    return sgn * m[n-1][n-1];
  endfunction

  function automatic logic [MAT_W-1:0] exp_pack(input int n);
    logic [MAT_W-1:0] m;
    m = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) m[(r * DIM + c) * ELEM_W +: ELEM_W] = ELEM_W'(el[r * n + c]);
    return m;
  endfunction

  // determinant unit: answers det_dly cycles after start rises, drops done_in once start falls
  always @(negedge clk) begin
    if (rst || bus.start !== 1'b1) begin
      dcnt = 0;
      bus.done_in = 1'b0;
    end else if (!det_never) begin
      dcnt++;
      bus.done_in = dcnt == det_dly;
      if (dcnt == det_dly) begin
        bus.det_in = ELEM_W'(det_f(bus.matriz_A, cur_n));
        dn_cyc = cyc + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int sz);
    bus.op_begin = 1'b1;
    bus.size = 3'(sz);
    tick;
    bus.op_begin = 1'b0;
  endtask

  task automatic feed(input bit tog, input int lim, output int lowrdy, output int stseen);
    int k, g;
    bit ph, acc;
    k = 0; g = 0; ph = 1'b0; lowrdy = 0; stseen = 0;
    while (k < lim && g < 400) begin
      bus.in_valid = tog ? ph : 1'b1;
      bus.in_data = ELEM_W'(el[k]);
      if (bus.in_ready !== 1'b1) lowrdy++;
      if (bus.start !== 1'b0) stseen++;
      acc = bus.in_valid && bus.in_ready;
      tick;
      if (acc) k++;
      ph = ~ph;
      g++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int rv_n, output int rv_cyc, output int chg, output bit hung);
    logic [MAT_W-1:0] snap;
    int i;
    snap = bus.matriz_A;
    rv_n = 0; rv_cyc = -1; chg = 0; i = 0;
    while (bus.busy === 1'b1 && i < 200) begin
      tick;
      i++;
      if (bus.result_valid === 1'b1) begin
        rv_n++;
        rv_cyc = cyc;
      end
      if (bus.matriz_A !== snap) chg++;
    end
    hung = bus.busy !== 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) tick;
    checks++; if ({bus.start, bus.in_ready, bus.busy, bus.result_valid, bus.error} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got=%b want=00000", {bus.start, bus.in_ready, bus.busy, bus.result_valid, bus.error}); end
    checks++; if (bus.matriz_A !== '0) begin errors++; $display("FAIL reset_mat got=%h want=0", bus.matriz_A); end
    checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result got=%0d want=0", bus.result); end
    rst = 1'b0;
    tick;
    checks++; if ({bus.busy, bus.in_ready, bus.start} !== 3'b0) begin errors++; $display("FAIL post_reset_idle got=%b want=000", {bus.busy, bus.in_ready, bus.start}); end
  endtask

  task automatic test_identity;
    int lr, ss, rv_n, rv_cyc, chg;
    bit hung;
    logic [ELEM_W-1:0] c4;
    cur_n = 4; det_dly = 6;
    for (int i = 0; i < 16; i++) el[i] = (i % 5 == 0) ? 1 : 0;
    start_op(4);
    feed(1'b0, 16, lr, ss);
    checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL id_start got=%b want=1", bus.start); end
    checks++; if (bus.matriz_A[7:0] !== 8'd1) begin errors++; $display("FAIL id_a00 got=%0d want=1", bus.matriz_A[7:0]); end
    checks++; if (bus.matriz_A[4*DIM*ELEM_W +: DIM*ELEM_W] !== '0) begin errors++; $display("FAIL id_row4 got=%h want=0", bus.matriz_A[4*DIM*ELEM_W +: DIM*ELEM_W]); end
    c4 = '0;
    for (int r = 0; r < DIM; r++) c4 |= bus.matriz_A[(r * DIM + 4) * ELEM_W +: ELEM_W];
    checks++; if (c4 !== '0) begin errors++; $display("FAIL id_col4 got=%h want=0", c4); end
    checks++; if (bus.matriz_A !== exp_pack(4)) begin errors++; $display("FAIL id_mat got=%h want=%h", bus.matriz_A, exp_pack(4)); end
    wait_result(rv_n, rv_cyc, chg, hung);
    checks++; if (hung) begin errors++; $display("FAIL id_done got=busy want=idle"); end
    checks++; if (bus.result !== 8'd1) begin errors++; $display("FAIL id_result got=%0d want=1", bus.result); end
    checks++; if (rv_n !== 1) begin errors++; $display("FAIL id_rv_pulses got=%0d want=1", rv_n); end
    checks++; if (rv_cyc !== dn_cyc) begin errors++; $display("FAIL id_rv_latency got=%0d want=%0d", rv_cyc, dn_cyc); end
  endtask

  task automatic test_diag_toggle;
    int lr, ss, rv_n, rv_cyc, chg;
    bit hung;
    cur_n = 4; det_dly = 6;
    for (int i = 0; i < 16; i++) el[i] = 0;
    el[0] = 2; el[5] = 3; el[10] = 1; el[15] = 2;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL dg_rdy_idle got=%b want=0", bus.in_ready); end
    start_op(4);
    checks++; if ({bus.in_ready, bus.busy} !== 2'b11) begin errors++; $display("FAIL dg_load_entry got=%b want=11", {bus.in_ready, bus.busy}); end
    feed(1'b1, 16, lr, ss);
    checks++; if (lr !== 0) begin errors++; $display("FAIL dg_rdy_load got=%0d low cycles want=0", lr); end
    checks++; if (ss !== 0) begin errors++; $display("FAIL dg_start_early got=%0d want=0", ss); end
    checks++; if ({bus.start, bus.in_ready} !== 2'b10) begin errors++; $display("FAIL dg_run_entry got=%b want=10", {bus.start, bus.in_ready}); end
    wait_result(rv_n, rv_cyc, chg, hung);
    checks++; if (bus.result !== 8'd12) begin errors++; $display("FAIL dg_result got=%0d want=12", bus.result); end
    checks++; if (rv_n !== 1 || hung) begin errors++; $display("FAIL dg_rv got=%0d hung=%0b want=1 hung=0", rv_n, hung); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL dg_rdy_after got=%b want=0", bus.in_ready); end
  endtask

  task automatic test_bad_size;
    int bad[4] = '{7, 0, 1, 6};
    foreach (bad[i]) begin
      start_op(bad[i]);
      checks++; if ({bus.error, bus.busy, bus.in_ready} !== 3'b100) begin errors++; $display("FAIL bad_size%0d got=%b want=100", bad[i], {bus.error, bus.busy, bus.in_ready}); end
      tick;
      checks++; if ({bus.error, bus.busy} !== 2'b00) begin errors++; $display("FAIL bad_size%0d_after got=%b want=00", bad[i], {bus.error, bus.busy}); end
    end
  endtask

  task automatic test_timeout;
    int lr, ss, cnt, early;
    det_never = 1'b1; cur_n = 2;
    for (int i = 0; i < 4; i++) el[i] = int'($urandom_range(0, 255));
    start_op(2);
    feed(1'b0, 4, lr, ss);
    cnt = 0; early = 0;
    while (bus.start === 1'b1 && cnt < 100) begin
      cnt++;
      if (bus.error !== 1'b0) early++;
      tick;
    end
    checks++; if (cnt !== TIMEOUT) begin errors++; $display("FAIL tmo_start_cycles got=%0d want=%0d", cnt, TIMEOUT); end
    checks++; if (early !== 0) begin errors++; $display("FAIL tmo_early_error got=%0d want=0", early); end
    checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL tmo_error got=%b want=1", bus.error); end
    checks++; if (bus.result !== '0) begin errors++; $display("FAIL tmo_result got=%0d want=0", bus.result); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got=%b want=0", bus.busy); end
    tick;
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL tmo_error_pulse got=%b want=0", bus.error); end
    det_never = 1'b0;
  endtask

  task automatic test_reset_abort;
    int lr, ss, rv_n, rv_cyc, chg;
    bit hung;
    cur_n = 4; det_dly = 6;
    for (int i = 0; i < 16; i++) el[i] = int'($urandom_range(0, 15));
    start_op(4);
    feed(1'b0, 9, lr, ss);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.start, bus.in_ready, bus.busy, bus.result_valid, bus.error} !== 5'b0) begin errors++; $display("FAIL abort_load_ctrl got=%b want=00000", {bus.start, bus.in_ready, bus.busy, bus.result_valid, bus.error}); end
    checks++; if (bus.matriz_A !== '0 || bus.result !== '0) begin errors++; $display("FAIL abort_load_data got=%h/%0d want=0/0", bus.matriz_A, bus.result); end
    rst = 1'b0;
    tick;
    start_op(4);
    feed(1'b0, 16, lr, ss);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.start, bus.busy} !== 2'b00) begin errors++; $display("FAIL abort_run got=%b want=00", {bus.start, bus.busy}); end
    rst = 1'b0;
    tick;
    for (int i = 0; i < 16; i++) el[i] = int'($urandom_range(0, 15));
    start_op(4);
    feed(1'b0, 16, lr, ss);
    wait_result(rv_n, rv_cyc, chg, hung);
    checks++; if (bus.result !== ELEM_W'(det_f(exp_pack(4), 4))) begin errors++; $display("FAIL abort_fresh_det got=%0d want=%0d", bus.result, ELEM_W'(det_f(exp_pack(4), 4))); end
    checks++; if (rv_n !== 1 || hung) begin errors++; $display("FAIL abort_fresh_rv got=%0d hung=%0b want=1 hung=0", rv_n, hung); end
  endtask

  task automatic test_run_ignore;
    int lr, ss, rv_n, rv_cyc, chg, bad;
    bit hung;
    logic [MAT_W-1:0] snap;
    cur_n = 3; det_dly = 6;
    for (int i = 0; i < 9; i++) el[i] = int'($urandom_range(0, 15));
    start_op(3);
    feed(1'b0, 9, lr, ss);
    snap = bus.matriz_A;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      bus.op_begin = 1'b1; bus.size = 3'd2; bus.in_valid = 1'b1; bus.in_data = ELEM_W'($urandom);
      tick;
      if (bus.matriz_A !== snap || bus.in_ready !== 1'b0 || bus.start !== 1'b1) bad++;
    end
    bus.op_begin = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL ign_run got=%0d disturbed cycles want=0", bad); end
    wait_result(rv_n, rv_cyc, chg, hung);
    bus.in_valid = 1'b0;
    checks++; if (chg !== 0) begin errors++; $display("FAIL ign_mat_stable got=%0d changes want=0", chg); end
    checks++; if (rv_n !== 1 || hung) begin errors++; $display("FAIL ign_rv got=%0d hung=%0b want=1 hung=0", rv_n, hung); end
    checks++; if (bus.result !== ELEM_W'(det_f(exp_pack(3), 3))) begin errors++; $display("FAIL ign_det got=%0d want=%0d", bus.result, ELEM_W'(det_f(exp_pack(3), 3))); end
    tick;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_no_queue got=%b want=0", bus.busy); end
  endtask

  task automatic test_random;
    int n, lr, ss, rv_n, rv_cyc, chg;
    bit hung;
    for (int it = 0; it < 8; it++) begin
      n = int'($urandom_range(2, 5));
      cur_n = n;
      det_dly = int'($urandom_range(1, 12));
      for (int i = 0; i < n * n; i++) el[i] = int'($urandom_range(0, 15));
      start_op(n);
      feed(1'($urandom), n * n, lr, ss);
      checks++; if (bus.matriz_A !== exp_pack(n)) begin errors++; $display("FAIL rnd%0d_mat got=%h want=%h", it, bus.matriz_A, exp_pack(n)); end
      checks++; if (bus.start !== 1'b1) begin errors++; $display("FAIL rnd%0d_start got=%b want=1", it, bus.start); end
      wait_result(rv_n, rv_cyc, chg, hung);
      checks++; if (bus.result !== ELEM_W'(det_f(exp_pack(n), n))) begin errors++; $display("FAIL rnd%0d_det n=%0d got=%0d want=%0d", it, n, bus.result, ELEM_W'(det_f(exp_pack(n), n))); end
      checks++; if (rv_n !== 1 || rv_cyc !== dn_cyc || hung) begin errors++; $display("FAIL rnd%0d_rv got=%0d@%0d want=1@%0d", it, rv_n, rv_cyc, dn_cyc); end
    end
  endtask

  initial begin
    bus.op_begin = 1'b0;
    bus.size = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    test_reset;
    test_identity;
    test_diag_toggle;
    test_bad_size;
    test_timeout;
    test_reset_abort;
    test_run_ignore;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=no finish want=finish");
    $fatal(1, "watchdog");
  end
endmodule
